// File: rtl/score_keeper_pkg.sv
// Shared constants and FSM state encoding for the score keeper.
package score_keeper_pkg;

    localparam int SCORE_W     = 7;
    localparam int ID_W        = 3;
    localparam int NUM_PLAYERS = 1 << ID_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_UPDATE  = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

endpackage

// File: rtl/score_keeper_table.sv
// Personal-best register file: registered read address, one write port,
// synchronous clear of every entry.
module score_table
    import score_keeper_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [ID_W-1:0]    raddr,
    output logic [SCORE_W-1:0] rdata,
    input  logic               we,
    input  logic [ID_W-1:0]    waddr,
    input  logic [SCORE_W-1:0] wdata
);

    logic [NUM_PLAYERS-1:0][SCORE_W-1:0] mem_q, mem_d;
    logic [ID_W-1:0]                     raddr_q, raddr_d;

    // Next contents: clear wins over write (the two never coincide in use).
    always_comb begin
        mem_d   = mem_q;
        raddr_d = raddr;
        if (clr) begin
            mem_d = '0;
        end else if (we) begin
            mem_d[waddr] = wdata;
        end else begin
            mem_d = mem_q;
        end
    end

    // Storage and read-address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q   <= '0;
            raddr_q <= '0;
        end else begin
            mem_q   <= mem_d;
            raddr_q <= raddr_d;
        end
    end

    assign rdata = mem_q[raddr_q];

endmodule

// File: rtl/score_keeper.sv
// Score-check responder: looks up personal and global bests, updates the
// records and reports personal/global wins with a one-cycle valid pulse.
module score_keeper
    import score_keeper_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               score_req,
    input  logic [SCORE_W-1:0] score_in,
    input  logic [ID_W-1:0]    intPlayID_in,
    input  logic               isGuest_in,
    input  logic               table_clr,
    output logic               valid,
    output logic               personalwin,
    output logic               globalwin,
    output logic               busy,
    output logic [SCORE_W-1:0] global_high,
    output logic [ID_W-1:0]    global_holder,
    output logic               global_guest
);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               guest_q, guest_d;
    logic [SCORE_W-1:0] pbest_q, pbest_d;
    logic [SCORE_W-1:0] gbest_q, gbest_d;
    logic               pwin_q, pwin_d;
    logic               gwin_q, gwin_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic [SCORE_W-1:0] ghigh_q, ghigh_d;
    logic [ID_W-1:0]    gholder_q, gholder_d;
    logic               gguest_q, gguest_d;

    logic               tbl_clr_s, tbl_we_s;
    logic [ID_W-1:0]    tbl_raddr_s;
    logic [SCORE_W-1:0] tbl_rdata_s;
    logic               pw_s, gw_s;

    // While idle the table address follows the incoming ID so the entry is
    // readable in LOOKUP; afterwards it holds the latched ID.
    assign tbl_raddr_s = (state_q == S_IDLE) ? intPlayID_in : id_q;

    score_table u_table (
        .clk   (clk),
        .rst   (rst),
        .clr   (tbl_clr_s),
        .raddr (tbl_raddr_s),
        .rdata (tbl_rdata_s),
        .we    (tbl_we_s),
        .waddr (id_q),
        .wdata (score_q)
    );

    // FSM next-state, request latching, compare and record-update logic.
    always_comb begin
        state_d   = state_q;
        score_d   = score_q;
        id_d      = id_q;
        guest_d   = guest_q;
        pbest_d   = pbest_q;
        gbest_d   = gbest_q;
        pwin_d    = pwin_q;
        gwin_d    = gwin_q;
        ghigh_d   = ghigh_q;
        gholder_d = gholder_q;
        gguest_d  = gguest_q;
        tbl_clr_s = 1'b0;
        tbl_we_s  = 1'b0;
        // Strict unsigned compares: ties and score 0 never win; guests never
        // earn a personal win.
        pw_s = !guest_q && (score_q > pbest_q);
        gw_s = (score_q > gbest_q);

        case (state_q)
            S_IDLE: begin
                if (score_req) begin
                    score_d = score_in;
                    id_d    = intPlayID_in;
                    guest_d = isGuest_in;
                    pwin_d  = 1'b0;
                    gwin_d  = 1'b0;
                    state_d = S_LOOKUP;
                end else if (table_clr) begin
                    tbl_clr_s = 1'b1;
                    ghigh_d   = '0;
                    gholder_d = '0;
                    gguest_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOOKUP: begin
                pbest_d = tbl_rdata_s;
                gbest_d = ghigh_q;
                state_d = S_UPDATE;
            end
            S_UPDATE: begin
                tbl_we_s = pw_s;
                if (gw_s) begin
                    ghigh_d   = score_q;
                    gholder_d = id_q;
                    gguest_d  = guest_q;
                end else begin
                    ghigh_d = ghigh_q;
                end
                pwin_d  = pw_s;
                gwin_d  = gw_s;
                state_d = S_RESPOND;
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        valid_d = (state_d == S_RESPOND);
        busy_d  = (state_d != S_IDLE);
    end

    // State, latched request, lookup results and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            score_q   <= '0;
            id_q      <= '0;
            guest_q   <= 1'b0;
            pbest_q   <= '0;
            gbest_q   <= '0;
            pwin_q    <= 1'b0;
            gwin_q    <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            ghigh_q   <= '0;
            gholder_q <= '0;
            gguest_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            score_q   <= score_d;
            id_q      <= id_d;
            guest_q   <= guest_d;
            pbest_q   <= pbest_d;
            gbest_q   <= gbest_d;
            pwin_q    <= pwin_d;
            gwin_q    <= gwin_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            ghigh_q   <= ghigh_d;
            gholder_q <= gholder_d;
            gguest_q  <= gguest_d;
        end
    end

    assign valid         = valid_q;
    assign personalwin   = pwin_q;
    assign globalwin     = gwin_q;
    assign busy          = busy_q;
    assign global_high   = ghigh_q;
    assign global_holder = gholder_q;
    assign global_guest  = gguest_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: directed scenarios plus randomized requests
// checked against a record-keeping model (arrays and plain compares).
module tb_score_keeper;
    import score_keeper_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               score_req = 1'b0;
    logic [SCORE_W-1:0] score_in = '0;
    logic [ID_W-1:0]    intPlayID_in = '0;
    logic               isGuest_in = 1'b0;
    logic               table_clr = 1'b0;
    logic               valid, personalwin, globalwin, busy, global_guest;
    logic [SCORE_W-1:0] global_high;
    logic [ID_W-1:0]    global_holder;

    int checks = 0;
    int failures = 0;

    // Reference records.
    int m_tbl [NUM_PLAYERS];
    int m_high, m_holder, m_guest;
    int exp_pw, exp_gw;

    score_keeper dut (
        .clk(clk), .rst(rst), .score_req(score_req), .score_in(score_in),
        .intPlayID_in(intPlayID_in), .isGuest_in(isGuest_in), .table_clr(table_clr),
        .valid(valid), .personalwin(personalwin), .globalwin(globalwin), .busy(busy),
        .global_high(global_high), .global_holder(global_holder), .global_guest(global_guest)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_PLAYERS; i++) m_tbl[i] = 0;
        m_high = 0; m_holder = 0; m_guest = 0;
    endtask

    task automatic model_req(input int s, input int id, input int g);
        exp_pw = (g == 0 && s > m_tbl[id]) ? 1 : 0;
        exp_gw = (s > m_high) ? 1 : 0;
        if (exp_pw == 1) m_tbl[id] = s;
        if (exp_gw == 1) begin m_high = s; m_holder = id; m_guest = g; end
    endtask

    task automatic chk_records(input string tag);
        chk({tag, ".pw"}, int'(personalwin), exp_pw);
        chk({tag, ".gw"}, int'(globalwin), exp_gw);
        chk({tag, ".ghigh"}, int'(global_high), m_high);
        chk({tag, ".gholder"}, int'(global_holder), m_holder);
        chk({tag, ".gguest"}, int'(global_guest), m_guest);
    endtask

    // One request; checks busy, 3-cycle latency, results and pulse width.
    task automatic send(input string tag, input int s, input int id, input int g, input bit clr_too);
        int n;
        @(negedge clk);
        score_req = 1'b1; score_in = SCORE_W'(s); intPlayID_in = ID_W'(id);
        isGuest_in = g[0]; table_clr = clr_too;
        @(negedge clk);
        score_req = 1'b0; table_clr = 1'b0;
        chk({tag, ".busy"}, int'(busy), 1);
        model_req(s, id, g);
        n = 0;
        while (valid !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, n, 2);
        chk_records(tag);
        @(negedge clk);
        chk({tag, ".valid_1cyc"}, int'(valid), 0);
        chk({tag, ".idle"}, int'(busy), 0);
        chk({tag, ".pw_hold"}, int'(personalwin), exp_pw);
    endtask

    initial begin
        int vcount;
        model_clear();
        exp_pw = 0; exp_gw = 0;

        // Reset state.
        repeat (2) @(negedge clk);
        chk("rst.valid", int'(valid), 0);
        chk("rst.busy", int'(busy), 0);
        chk_records("rst");
        rst = 1'b0;

        // New record, tie, then one higher.
        send("t1", 40, 2, 0, 1'b0);
        send("t2a", 40, 2, 0, 1'b0);
        send("t2b", 41, 2, 0, 1'b0);

        // Guest takes global only; table untouched for that ID.
        send("t3a", 100, 5, 1, 1'b0);
        send("t3b", 90, 5, 0, 1'b0);

        // Extra requests while busy are ignored.
        @(negedge clk);
        score_req = 1'b1; score_in = 7'd120; intPlayID_in = 3'd4; isGuest_in = 1'b0;
        model_req(120, 4, 0);
        vcount = 0;
        @(negedge clk);
        score_in = 7'd127; intPlayID_in = 3'd3;
        for (int i = 0; i < 3; i++) begin
            if (valid === 1'b1) vcount++;
            @(negedge clk);
        end
        score_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (valid === 1'b1) vcount++;
            @(negedge clk);
        end
        chk("t4.valid_count", vcount, 1);
        chk_records("t4");

        // Clear in IDLE, then clear coincident with a request.
        @(negedge clk);
        table_clr = 1'b1;
        @(negedge clk);
        table_clr = 1'b0;
        model_clear();
        chk("t5.clr_high", int'(global_high), 0);
        send("t5a", 1, 0, 0, 1'b0);
        send("t5b", 2, 0, 0, 1'b1);
        send("t5c", 2, 0, 0, 1'b0);

        // Reset during UPDATE aborts without a pulse.
        @(negedge clk);
        score_req = 1'b1; score_in = 7'd77; intPlayID_in = 3'd1; isGuest_in = 1'b0;
        @(negedge clk);
        score_req = 1'b0;
        @(negedge clk);
        chk("t6.in_update_busy", int'(busy), 1);
        rst = 1'b1;
        #1;
        model_clear();
        exp_pw = 0; exp_gw = 0;
        chk("t6.valid", int'(valid), 0);
        chk("t6.busy", int'(busy), 0);
        chk_records("t6");
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            if (valid === 1'b1) vcount++;
            @(negedge clk);
        end
        chk("t6.no_pulse", vcount, 0);
        send("t6b", 127, 7, 0, 1'b0);

        // Randomized traffic against the model.
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 15) == 0) begin
                @(negedge clk);
                table_clr = 1'b1;
                @(negedge clk);
                table_clr = 1'b0;
                model_clear();
            end
            send("rnd", int'($urandom_range(0, 127)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 1 : 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
